// File: rtl/pifo_req_issuer.sv
// pifo_req_issuer
//   Request-side front end for the multi-tree SRAM PIFO. Accepts push/pop
//   requests over valid/ready, spaces issues to trees sharing a root RPU,
//   tracks per-tree occupancy (dropping pushes to full trees, answering pops
//   to empty trees locally) and tags pops so returned data is matched to its
//   tree in acceptance order.
//
// Ports
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_req_valid/o_req_ready  request handshake (ready ignores valid)
//   i_req_op                 0 = push, 1 = pop
//   i_req_tree, i_req_data   target tree, push payload
//   o_tree_id, o_push, o_push_data, o_pop   shared PIFO request port
//   i_pop_data               PIFO pop data, valid POP_LAT cycles after o_pop
//   o_rsp_valid/tree/data/empty             pop response (no backpressure)
//   o_drop                   pulse: push dropped, tree full
//
// Optional feature
//   PIFO_REQ_STATS_EN: adds 32-bit o_push_cnt, o_pop_cnt, o_drop_cnt counting
//   issued pushes, issued (non-empty) pops and drops.
module pifo_req_issuer #(
  parameter int PTW       = 16,
  parameter int MTW       = 0,
  parameter int CTW       = 10,
  parameter int LEVEL     = 4,
  parameter int TREE_NUM  = 4,
  parameter int ISSUE_GAP = 2,
  parameter int POP_LAT   = 1,
  parameter int CAP       = 2*(2**LEVEL-1),
  localparam int TREE_NUM_BITS = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1,
  localparam int DW            = MTW + PTW
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_op,
  input  logic [TREE_NUM_BITS-1:0] i_req_tree,
  input  logic [DW-1:0]            i_req_data,
  output logic [TREE_NUM_BITS-1:0] o_tree_id,
  output logic                     o_push,
  output logic [DW-1:0]            o_push_data,
  output logic                     o_pop,
  input  logic [DW-1:0]            i_pop_data,
  output logic                     o_rsp_valid,
  output logic [TREE_NUM_BITS-1:0] o_rsp_tree,
  output logic [DW-1:0]            o_rsp_data,
  output logic                     o_rsp_empty,
`ifdef PIFO_REQ_STATS_EN
  output logic [31:0]              o_push_cnt,
  output logic [31:0]              o_pop_cnt,
  output logic [31:0]              o_drop_cnt,
`endif
  output logic                     o_drop
);

  localparam int LEVEL_BITS = (LEVEL > 1) ? $clog2(LEVEL) : 1;
  localparam int CDW        = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  logic [CDW-1:0]           cooldown [LEVEL];
  logic [CTW-1:0]           occ      [TREE_NUM];
  logic                     tag_v     [POP_LAT+1];
  logic [TREE_NUM_BITS-1:0] tag_tree  [POP_LAT+1];
  logic                     tag_empty [POP_LAT+1];

  logic [LEVEL_BITS-1:0] req_root;
  logic accept, can_push, can_pop;
  logic issue_push, issue_pop, issue_drop;

  assign req_root    = LEVEL_BITS'(32'(i_req_tree) & (LEVEL-1));
  assign o_req_ready = !i_rst && (cooldown[req_root] == '0);
  assign accept      = i_req_valid && o_req_ready;
  assign can_push    = occ[i_req_tree] < CTW'(CAP);
  assign can_pop     = occ[i_req_tree] != '0;
  assign issue_push  = accept && !i_req_op && can_push;
  assign issue_drop  = accept && !i_req_op && !can_push;
  assign issue_pop   = accept && i_req_op && can_pop;

  // Per-root issue spacing: the accepting root reloads, all others count down.
  always_ff @(posedge i_clk) begin
    for (int unsigned r = 0; r < LEVEL; r++) begin
      if (i_rst)
        cooldown[r] <= '0;
      else if (accept && (LEVEL_BITS'(r) == req_root))
        cooldown[r] <= CDW'(ISSUE_GAP-1);
      else if (cooldown[r] != '0)
        cooldown[r] <= cooldown[r] - CDW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned t = 0; t < TREE_NUM; t++) occ[t] <= '0;
    end else if (issue_push) begin
      occ[i_req_tree] <= occ[i_req_tree] + CTW'(1);
    end else if (issue_pop) begin
      occ[i_req_tree] <= occ[i_req_tree] - CTW'(1);
    end
  end

  // Issue port: pulses for one cycle; tree id and payload hold until the next issue.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_push      <= 1'b0;
      o_pop       <= 1'b0;
      o_drop      <= 1'b0;
      o_tree_id   <= '0;
      o_push_data <= '0;
    end else begin
      o_push <= issue_push;
      o_pop  <= issue_pop;
      o_drop <= issue_drop;
      if (issue_push || issue_pop) o_tree_id <= i_req_tree;
      if (issue_push) o_push_data <= i_req_data;
    end
  end

  // Every accepted pop (empty or not) rides the same fixed-length pipe, so
  // locally answered empties stay ordered with real PIFO returns.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i <= POP_LAT; i++) begin
        tag_v[i]     <= 1'b0;
        tag_tree[i]  <= '0;
        tag_empty[i] <= 1'b0;
      end
    end else begin
      tag_v[0]     <= accept && i_req_op;
      tag_tree[0]  <= i_req_tree;
      tag_empty[0] <= !can_pop;
      for (int unsigned i = 1; i <= POP_LAT; i++) begin
        tag_v[i]     <= tag_v[i-1];
        tag_tree[i]  <= tag_tree[i-1];
        tag_empty[i] <= tag_empty[i-1];
      end
    end
  end

  always_comb begin
    o_rsp_valid = tag_v[POP_LAT] && !i_rst;
    o_rsp_tree  = '0;
    o_rsp_empty = 1'b0;
    o_rsp_data  = '0;
    if (o_rsp_valid) begin
      o_rsp_tree  = tag_tree[POP_LAT];
      o_rsp_empty = tag_empty[POP_LAT];
      o_rsp_data  = tag_empty[POP_LAT] ? '1 : i_pop_data;
    end
  end

`ifdef PIFO_REQ_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_push_cnt <= '0;
      o_pop_cnt  <= '0;
      o_drop_cnt <= '0;
    end else begin
      o_push_cnt <= o_push_cnt + 32'(issue_push);
      o_pop_cnt  <= o_pop_cnt  + 32'(issue_pop);
      o_drop_cnt <= o_drop_cnt + 32'(issue_drop);
    end
  end
`endif

endmodule

// File: tb/tb_pifo_req_issuer.sv
// Directed bench for pifo_req_issuer (TREE_NUM=8, LEVEL=4, CAP=30,
// ISSUE_GAP=2, POP_LAT=1). Pop responses are checked against a scoreboard
// queue filled when each pop is accepted; issue pulses are checked against a
// per-tree occupancy model.
module tb_pifo_req_issuer;
  localparam int TN      = 8;
  localparam int POP_LAT = 1;
  localparam int CAP     = 30;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_op;
  logic [2:0]  i_req_tree;
  logic [15:0] i_req_data;
  logic [2:0]  o_tree_id;
  logic        o_push;
  logic [15:0] o_push_data;
  logic        o_pop;
  logic [15:0] i_pop_data;
  logic        o_rsp_valid;
  logic [2:0]  o_rsp_tree;
  logic [15:0] o_rsp_data;
  logic        o_rsp_empty;
  logic        o_drop;

  pifo_req_issuer #(.TREE_NUM(TN)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_op(i_req_op), .i_req_tree(i_req_tree), .i_req_data(i_req_data),
    .o_tree_id(o_tree_id), .o_push(o_push), .o_push_data(o_push_data),
    .o_pop(o_pop), .i_pop_data(i_pop_data),
    .o_rsp_valid(o_rsp_valid), .o_rsp_tree(o_rsp_tree),
    .o_rsp_data(o_rsp_data), .o_rsp_empty(o_rsp_empty),
    .o_drop(o_drop)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [2:0]  tree;
    logic        empty;
    logic [15:0] data;
    int          due;
  } rsp_t;

  rsp_t sb[$];
  int   occ_m [TN];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: check any response at the falling edge, then step past the rising edge.
  task automatic tick();
    rsp_t e;
    @(negedge i_clk);
    if (o_rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(o_rsp_valid), 0);
      end else begin
        e = sb.pop_front();
        chk("rsp_tree",  32'(o_rsp_tree),  32'(e.tree));
        chk("rsp_empty", 32'(o_rsp_empty), 32'(e.empty));
        chk("rsp_data",  32'(o_rsp_data),  32'(e.data));
        chk("rsp_cycle", cyc, e.due);
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      chk("rsp_missing", 32'(o_rsp_valid), 1);
      sb.delete(0);
    end
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic req(input logic op, input logic [2:0] tree, input logic [15:0] data,
                     output int waited);
    logic exp_issue;
    i_req_valid = 1'b1;
    i_req_op    = op;
    i_req_tree  = tree;
    i_req_data  = data;
    #1;
    waited = 0;
    while (o_req_ready !== 1'b1 && waited < 8) begin
      tick();
      waited++;
    end
    if (waited == 8) chk("ready_timeout", 32'(o_req_ready), 1);
    if (op) begin
      exp_issue = occ_m[tree] > 0;
      sb.push_back('{tree, !exp_issue, exp_issue ? i_pop_data : 16'hFFFF, cyc + 1 + POP_LAT});
    end else begin
      exp_issue = occ_m[tree] < CAP;
    end
    tick();
    i_req_valid = 1'b0;
    chk("push", 32'(o_push), 32'(!op && exp_issue));
    chk("pop",  32'(o_pop),  32'(op && exp_issue));
    chk("drop", 32'(o_drop), 32'(!op && !exp_issue));
    if (exp_issue) chk("tree_id", 32'(o_tree_id), 32'(tree));
    if (!op && exp_issue) chk("push_data", 32'(o_push_data), 32'(data));
    if (exp_issue) occ_m[tree] += op ? -1 : 1;
  endtask

  task automatic chk_all_zero();
    chk("rst_ready",     32'(o_req_ready), 0);
    chk("rst_tree_id",   32'(o_tree_id),   0);
    chk("rst_push",      32'(o_push),      0);
    chk("rst_push_data", 32'(o_push_data), 0);
    chk("rst_pop",       32'(o_pop),       0);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 0);
    chk("rst_rsp_tree",  32'(o_rsp_tree),  0);
    chk("rst_rsp_data",  32'(o_rsp_data),  0);
    chk("rst_rsp_empty", 32'(o_rsp_empty), 0);
    chk("rst_drop",      32'(o_drop),      0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    i_rst       = 1'b1;
    i_req_valid = 1'b0;
    i_req_op    = 1'b0;
    i_req_tree  = '0;
    i_req_data  = '0;
    i_pop_data  = 16'h1234;
    for (int t = 0; t < TN; t++) occ_m[t] = 0;

    // Reset held for three rising edges.
    @(posedge i_clk);
    #1;
    repeat (2) begin
      chk_all_zero();
      tick();
    end
    i_rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(o_req_ready), 1);

    // Empty pop answered locally with all ones.
    req(1'b1, 3'd2, 16'h0000, w);
    repeat (2) tick();

    // Same-root spacing versus different-root back-to-back.
    req(1'b0, 3'd1, 16'h0005, w);
    i_req_valid = 1'b1;
    i_req_op    = 1'b0;
    i_req_tree  = 3'd5;
    i_req_data  = 16'h0007;
    #1;
    chk("same_root_ready", 32'(o_req_ready), 0);
    req(1'b0, 3'd5, 16'h0007, w);
    chk("same_root_wait", w, 1);
    tick();
    chk("push_pulse_end", 32'(o_push), 0);
    chk("tree_id_hold", 32'(o_tree_id), 5);
    chk("push_data_hold", 32'(o_push_data), 16'h0007);
    req(1'b0, 3'd1, 16'h0008, w);
    req(1'b0, 3'd2, 16'h0009, w);
    chk("diff_root_wait", w, 0);

    // Pop with returned data.
    i_pop_data = 16'h0005;
    req(1'b1, 3'd1, 16'h0000, w);
    repeat (2) tick();

    // Fill tree0 to CAP, overflow drop, pop from full, push again.
    i_pop_data = 16'h00AA;
    for (int k = 0; k < CAP; k++) req(1'b0, 3'd0, 16'(k + 1), w);
    req(1'b0, 3'd0, 16'hBEEF, w);
    req(1'b1, 3'd0, 16'h0000, w);
    req(1'b0, 3'd0, 16'h0042, w);
    repeat (3) tick();

    // Reset while a pop is in flight: its response is discarded.
    i_pop_data = 16'h0033;
    req(1'b1, 3'd0, 16'h0000, w);
    i_rst = 1'b1;
    sb.delete();
    for (int t = 0; t < TN; t++) occ_m[t] = 0;
    tick();
    i_rst = 1'b0;
    chk("rst_no_rsp", 32'(o_rsp_valid), 0);
    tick();
    req(1'b1, 3'd0, 16'h0000, w);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pifo_req_issuer.md
# pifo_req_issuer

Request-side front end for the multi-tree SRAM PIFO top. It accepts push and pop requests from the traffic manager over a valid/ready handshake and drives the PIFO's single shared push/pop/tree-id port. It enforces root-RPU issue spacing and tracks per-tree occupancy, which lets it drop pushes to a full tree and answer pops to an empty tree locally. It then matches returned pop data back to its tree through a latency-tagged response pipeline.

## Interface
Parameters:
- PTW, 16, payload width
- MTW, 0, metadata width
- CTW, 10, occupancy counter width; must satisfy 2^CTW > CAP
- LEVEL, 4, PIFO levels (equal to the RPU count)
- TREE_NUM, 4, number of logical trees
- ISSUE_GAP, 2, minimum cycles between issues to trees sharing a root RPU (≥1)
- POP_LAT, 1, cycles from o_pop asserted to i_pop_data valid (≥0)
- CAP, 2*(2**LEVEL-1), entries per tree
- Derived: TREE_NUM_BITS = $clog2(TREE_NUM), LEVEL_BITS = $clog2(LEVEL), DW = MTW+PTW

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request accepted when valid&ready
- i_req_op  in  1  0 = push, 1 = pop
- i_req_tree  in  TREE_NUM_BITS  target tree
- i_req_data  in  DW  push data (ignored for pop)
- o_tree_id  out  TREE_NUM_BITS  to PIFO i_tree_id
- o_push  out  1  to PIFO i_push
- o_push_data  out  DW  to PIFO i_push_data
- o_pop  out  1  to PIFO i_pop
- i_pop_data  in  DW  from PIFO o_pop_data
- o_rsp_valid  out  1  pop response valid, one-cycle pulse, no backpressure
- o_rsp_tree  out  TREE_NUM_BITS  tree of the response
- o_rsp_data  out  DW  popped data; all ones when empty
- o_rsp_empty  out  1  pop targeted an empty tree
- o_drop  out  1  one-cycle pulse: push dropped, tree full

## Operation
- Root RPU = tree & (LEVEL-1). Each root has a cooldown counter.
- o_req_ready = !i_rst && cooldown[root(i_req_tree)] == 0. It is combinational on i_req_tree and does not depend on i_req_valid.
- On accept, cooldown[root] is loaded with ISSUE_GAP-1. All nonzero cooldowns decrement each cycle.
- Occupancy occ[tree] is CTW bits and starts at 0 after reset.
- Accepted push:
  - If occ < CAP: drive o_push with o_tree_id and o_push_data on the next cycle, then occ+1.
  - Otherwise: pulse o_drop on the next cycle, leave o_push low, leave occ unchanged.
- Accepted pop:
  - If occ > 0: drive o_pop with o_tree_id on the next cycle, then occ-1.
  - Otherwise: o_pop stays low. The pop still enters the tag pipeline, marked empty.
- Tag pipeline: POP_LAT+1 stages, each holding {valid, tree, empty}. Entry happens on every accepted pop.
  - At exit, o_rsp_valid=1 and o_rsp_tree is taken from the tag.
  - o_rsp_data = empty ? all ones : i_pop_data, sampled in the exit cycle.
  - o_rsp_empty = tag.empty.
- Responses leave in acceptance order. A skipped empty pop and a real pop can never reorder.
- A cooldown-blocked request is not accepted. The requester holds valid and data stable until accepted.

## Timing
- Reset: all outputs are 0, including o_rsp_data, o_push_data and o_tree_id. o_req_ready is 0 while i_rst=1 and 1 on the first cycle after reset. Cooldowns, occupancy and tags are cleared.
- Issue latency: accept at cycle t gives o_push, o_pop or o_drop at t+1, each a one-cycle pulse. o_tree_id and o_push_data hold their value until the next issue.
- Response latency: a pop accepted at t responds at t+1+POP_LAT, whether the tree was empty or not.
- Throughput: one request per cycle across different roots. For the same root, at most one request every ISSUE_GAP cycles; ISSUE_GAP=1 means no restriction.
- Counter updates at the boundaries:
  - occ==CAP push → drop.
  - occ==0 pop → empty response.
  - occ==CAP pop → CAP-1.
  - Occupancy never wraps.
- Reset mid-operation: in-flight tags are discarded and no response is produced for them. Occupancy returns to 0 because the PIFO is reset in the same cycle.

## Configuration
- PIFO_REQ_STATS_EN:
  - Defined: adds outputs o_push_cnt, o_pop_cnt and o_drop_cnt, each 32 bits.
    - o_push_cnt counts issued pushes; o_pop_cnt counts issued (non-empty) pops; o_drop_cnt counts drops.
    - All three wrap modulo 2^32 and reset to 0.
  - Undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- Reset: hold i_rst for 3 cycles → all outputs 0 during reset; o_req_ready=1 on the first cycle after reset.
- Push ordering (TREE_NUM=8): push tree1 data 0x0005 at t → o_push=1, o_tree_id=1, o_push_data=0x0005 at t+1.
  - A push to tree5 presented at t+1 sees o_req_ready=0 and is accepted at t+2 (ISSUE_GAP=2).
  - A push to tree2 at t+1 is accepted immediately.
- Empty pop: pop tree2 after reset → o_pop stays 0; at t+2 (POP_LAT=1) o_rsp_valid=1, o_rsp_tree=2, o_rsp_empty=1, o_rsp_data=0xFFFF.
- Pop data return: push 0x0005 to tree1, then pop tree1 at t → o_pop at t+1; drive i_pop_data=0x0005 at t+2 → o_rsp_data=0x0005, o_rsp_empty=0, o_rsp_tree=1.
- Full tree (LEVEL=4, CAP=30): 30 pushes to tree0 → 30 o_push pulses. The 31st push → o_drop=1 at t+1, no o_push. A following pop gets o_pop=1, and the next push is issued normally.
- Reset mid-flight: pop accepted at t, i_rst at t+1 → no o_rsp_valid at t+2; occupancy 0 (a later pop returns empty).
